led_matrix_scan_driver: RTL and testbench

LED_MATRIX_SCAN_DRIVER -- requirements
Module: led_matrix_scan_driver

---
 rtl/led_matrix_pkg.sv | 17 +
 rtl/led_scan_timer.sv | 51 +++++
 rtl/led_matrix_scan_driver.sv | 127 ++++++++++++
 tb/tb_led_matrix_scan_driver.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_matrix_pkg.sv
// Shared defaults and pixel addressing for the LED matrix scan driver.
// Optional PWM dimming is enabled with LED_MATRIX_BRIGHTNESS_EN.
package led_matrix_pkg;

    localparam int unsigned DEF_ROWS  = 8;
    localparam int unsigned DEF_COLS  = 8;
    localparam int unsigned DEF_DIV_W = 12;
    localparam int unsigned DEF_PWM_W = 4;

    // Flat frame bit index of row r, column c.
    function automatic int unsigned pix_idx(input int unsigned r,
                                            input int unsigned c,
                                            input int unsigned cols);
        return r * cols + c;
    endfunction

endpackage

// File: rtl/led_scan_timer.sv
// Free-running column prescaler, dwell tick and PWM on-phase compare.
// With LED_MATRIX_BRIGHTNESS_EN defined the on-phase follows brightness; otherwise always on.
module led_scan_timer
    import led_matrix_pkg::*;
#(
    parameter int unsigned DIV_W = DEF_DIV_W,
    parameter int unsigned PWM_W = DEF_PWM_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PWM_W-1:0] brightness,
    output logic             tick,
    output logic             pwm_on
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    assign cnt_d = cnt_q + DIV_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = &cnt_q;

`ifdef LED_MATRIX_BRIGHTNESS_EN
    logic [PWM_W-1:0] brightness_q;

    // Brightness only changes at dwell boundaries so a column never sees two duty cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            brightness_q <= '0;
        end else if (tick) begin
            brightness_q <= brightness;
        end
    end

    assign pwm_on = (cnt_q[DIV_W-1 -: PWM_W] < brightness_q);
`else
    logic [PWM_W-1:0] brightness_unused;

    assign brightness_unused = brightness;
    assign pwm_on            = 1'b1;
`endif

endmodule

// File: rtl/led_matrix_scan_driver.sv
// Column-scanned LED matrix driver with double-buffered frames and tear-free swaps.
// Define LED_MATRIX_BRIGHTNESS_EN to enable PWM dimming from the brightness port.
module led_matrix_scan_driver
    import led_matrix_pkg::*;
#(
    parameter int unsigned ROWS  = DEF_ROWS,
    parameter int unsigned COLS  = DEF_COLS,
    parameter int unsigned DIV_W = DEF_DIV_W,
    parameter int unsigned PWM_W = DEF_PWM_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 an,
    input  logic [ROWS*COLS-1:0] frame,
    input  logic                 load,
    input  logic [PWM_W-1:0]     brightness,
    output logic                 pending,
    output logic                 frame_done,
    output logic [ROWS-1:0]      rows,
    output logic [COLS-1:0]      colms
);

    localparam int unsigned PIX   = ROWS * COLS;
    localparam int unsigned COL_W = $clog2(COLS);
    localparam int unsigned IDX_W = $clog2(PIX);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

    logic tick;
    logic pwm_on;

    led_scan_timer #(
        .DIV_W (DIV_W),
        .PWM_W (PWM_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .brightness (brightness),
        .tick       (tick),
        .pwm_on     (pwm_on)
    );

    logic [COL_W-1:0] col_q,        col_d;
    logic [PIX-1:0]   active_q,     active_d;
    logic [PIX-1:0]   pend_buf_q,   pend_buf_d;
    logic             pending_q,    pending_d;
    logic             frame_done_q, frame_done_d;
    logic [ROWS-1:0]  rows_q,       rows_d;
    logic [COLS-1:0]  colms_q,      colms_d;

    logic [ROWS-1:0]  row_pix;
    logic [COLS-1:0]  col_sel;
    logic             last_col;
    logic             swap;
    logic             show;

    assign last_col = (col_q == LAST_COL);
    // While blanked any tick is a safe swap point; while scanning only the frame wrap is.
    assign swap     = pending_q && tick && (!en || last_col);

    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        logic [IDX_W-1:0] idx;
        assign idx         = IDX_W'(pix_idx(gi, 32'(col_q), COLS));
        assign row_pix[gi] = active_q[idx];
    end

    for (genvar gi = 0; gi < COLS; gi++) begin : g_col
        assign col_sel[gi] = (col_q == COL_W'(gi));
    end

    always_comb begin
        col_d        = col_q;
        active_d     = active_q;
        pend_buf_d   = pend_buf_q;
        pending_d    = pending_q;
        frame_done_d = tick && en && last_col;
        show         = en && pwm_on;
        rows_d       = {ROWS{an}};
        colms_d      = {COLS{~an}};

        if (tick && en) begin
            col_d = last_col ? '0 : col_q + COL_W'(1);
        end

        if (swap) begin
            active_d  = pend_buf_q;
            pending_d = 1'b0;
        end

        // A coinciding load wins the pending flag: the swap above already took the old data.
        if (load) begin
            pend_buf_d = frame;
            pending_d  = 1'b1;
        end

        if (show) begin
            rows_d  = row_pix ^ {ROWS{an}};
            colms_d = col_sel ^ {COLS{~an}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            active_q     <= '0;
            pend_buf_q   <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            rows_q       <= {ROWS{an}};
            colms_q      <= {COLS{~an}};
        end else begin
            col_q        <= col_d;
            active_q     <= active_d;
            pend_buf_q   <= pend_buf_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
            rows_q       <= rows_d;
            colms_q      <= colms_d;
        end
    end

    assign pending    = pending_q;
    assign frame_done = frame_done_q;
    assign rows       = rows_q;
    assign colms      = colms_q;

endmodule

// File: tb/tb_led_matrix_scan_driver.sv
// Directed bench for led_matrix_scan_driver at ROWS=COLS=4, DIV_W=4, PWM_W=2.
// Build with LED_MATRIX_BRIGHTNESS_EN to exercise the PWM dimming expectations.
module tb_led_matrix_scan_driver;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int DIV_W = 4;
    localparam int PWM_W = 2;

`ifdef LED_MATRIX_BRIGHTNESS_EN
    localparam int ON_B1 = 4;
    localparam int ON_B0 = 0;
`else
    localparam int ON_B1 = 16;
    localparam int ON_B0 = 16;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en;
    logic                 an;
    logic [ROWS*COLS-1:0] frame;
    logic                 load;
    logic [PWM_W-1:0]     brightness;
    logic                 pending;
    logic                 frame_done;
    logic [ROWS-1:0]      rows;
    logic [COLS-1:0]      colms;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    led_matrix_scan_driver #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .DIV_W (DIV_W),
        .PWM_W (PWM_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .an         (an),
        .frame      (frame),
        .load       (load),
        .brightness (brightness),
        .pending    (pending),
        .frame_done (frame_done),
        .rows       (rows),
        .colms      (colms)
    );

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("  ok   %s = %0h", tag, got);
        end
    endtask

    task automatic wait_fd(input string tag, input int budget);
        int n;
        n = 0;
        while (frame_done !== 1'b1 && n < budget) begin
            step(1);
            n++;
        end
        chk(tag, 32'(frame_done), 32'h1);
    endtask

    // Count samples over 16 cycles where rows (and optionally colms) match.
    task automatic count_match(input logic [3:0] r, input logic [3:0] c,
                               input bit use_c, output int hits);
        hits = 0;
        for (int i = 0; i < 16; i++) begin
            if (rows == r && (!use_c || colms == c)) hits++;
            step(1);
        end
    endtask

    initial begin
        int n;
        rst        = 1'b1;
        en         = 1'b0;
        an         = 1'b0;
        load       = 1'b0;
        frame      = '0;
        brightness = 2'd1;
        step(3);
        chk("rst_rows",    32'(rows),       32'h0);
        chk("rst_colms",   32'(colms),      32'hF);
        chk("rst_pending", 32'(pending),    32'h0);
        chk("rst_fdone",   32'(frame_done), 32'h0);

`ifndef LED_MATRIX_BRIGHTNESS_EN
        // Single pixel at row 0, column 0.
        rst = 1'b0; en = 1'b1; load = 1'b1; frame = 16'h0001;
        step(1);
        load = 1'b0;
        chk("load_pending", 32'(pending), 32'h1);
        wait_fd("fd_first", 100);
        step(1);
        chk("c0_rows",  32'(rows),  32'h1);
        chk("c0_colms", 32'(colms), 32'hE);
        n = 0;
        while (colms == 4'hE && n < 40) begin
            n++;
            step(1);
        end
        chk("dwell_c0", 32'(n), 32'd16);
        chk("c1_rows",  32'(rows),  32'h0);
        chk("c1_colms", 32'(colms), 32'hD);
        step(16);
        chk("c2_colms", 32'(colms), 32'hB);
        step(16);
        chk("c3_rows",  32'(rows),  32'h0);
        chk("c3_colms", 32'(colms), 32'h7);
        step(14);
        chk("fd_before_wrap", 32'(frame_done), 32'h0);
        step(1);
        chk("fd_at_wrap", 32'(frame_done), 32'h1);

        // Two loads within a frame: display holds until the wrap, last load wins.
        step(32);
        load = 1'b1; frame = 16'hFFFF;
        step(1);
        load = 1'b0;
        chk("ldFF_pending", 32'(pending), 32'h1);
        chk("ldFF_rows",    32'(rows),    32'h0);
        chk("ldFF_colms",   32'(colms),   32'hB);
        step(5);
        load = 1'b1; frame = 16'h000F;
        step(1);
        load = 1'b0;
        chk("ld0F_rows",    32'(rows),    32'h0);
        wait_fd("fd_swap0F", 100);
        chk("swap0F_pending", 32'(pending), 32'h0);
        step(1);
        chk("0F_c0_rows", 32'(rows), 32'h1);
        step(16);
        chk("0F_c1_rows",  32'(rows),  32'h1);
        chk("0F_c1_colms", 32'(colms), 32'hD);

        // Load coinciding with the wrapping tick.
        load = 1'b1; frame = 16'h00F0;
        step(1);
        load = 1'b0;
        chk("ldF0_pending", 32'(pending), 32'h1);
        step(45);
        chk("pre_wrap_fd", 32'(frame_done), 32'h0);
        load = 1'b1; frame = 16'hF000;
        step(1);
        load = 1'b0;
        chk("coinc_fd",      32'(frame_done), 32'h1);
        chk("coinc_pending", 32'(pending),    32'h1);
        step(1);
        chk("F0_c0_rows", 32'(rows), 32'h2);
        wait_fd("fd_swapF000", 100);
        chk("F000_pending", 32'(pending), 32'h0);
        step(1);
        chk("F000_c0_rows", 32'(rows), 32'h8);

        // Blanked with a pending frame: swap on the next tick, column held.
        load = 1'b1; frame = 16'h0F00;
        step(1);
        load = 1'b0;
        step(18);
        en = 1'b0;
        step(1);
        chk("blank_rows",    32'(rows),    32'h0);
        chk("blank_colms",   32'(colms),   32'hF);
        chk("blank_pending", 32'(pending), 32'h1);
        step(10);
        chk("blank_pend_pre", 32'(pending), 32'h1);
        step(1);
        chk("blank_swap_pending", 32'(pending),    32'h0);
        chk("blank_no_fd",        32'(frame_done), 32'h0);
        en = 1'b1;
        step(1);
        chk("resume_rows",  32'(rows),  32'h4);
        chk("resume_colms", 32'(colms), 32'hD);
        an = 1'b1;
        step(1);
        chk("an1_rows",  32'(rows),  32'hB);
        chk("an1_colms", 32'(colms), 32'h2);

        // Reset mid-frame drops the pending frame and restarts at column 0.
        load = 1'b1; frame = 16'hFFFF;
        step(1);
        load = 1'b0;
        chk("prerst_pending", 32'(pending), 32'h1);
        rst = 1'b1;
        step(1);
        chk("rst2_pending", 32'(pending), 32'h0);
        chk("rst2_rows",    32'(rows),    32'hF);
        chk("rst2_colms",   32'(colms),   32'h0);
        rst = 1'b0;
        step(1);
        chk("restart_colms", 32'(colms), 32'h1);
        chk("restart_rows",  32'(rows),  32'hF);
        step(15);
        chk("restart_c0_end", 32'(colms), 32'h1);
        step(1);
        chk("restart_c1", 32'(colms), 32'h2);
`endif

        // Brightness duty, then the same with inverted polarity.
        rst = 1'b1; an = 1'b0; en = 1'b1; brightness = 2'd1;
        step(2);
        rst = 1'b0; load = 1'b1; frame = 16'hFFFF;
        step(1);
        load = 1'b0;
        wait_fd("fd_bright", 100);
        step(20);
        count_match(4'hF, 4'h0, 1'b0, n);
        chk("duty_b1_an0", 32'(n), 32'(ON_B1));
        brightness = 2'd0;
        step(17);
        count_match(4'hF, 4'h0, 1'b0, n);
        chk("duty_b0_an0", 32'(n), 32'(ON_B0));
        an = 1'b1; brightness = 2'd1;
        step(17);
        count_match(4'h0, 4'h0, 1'b0, n);
        chk("duty_b1_an1", 32'(n), 32'(ON_B1));
        count_match(4'hF, 4'h0, 1'b1, n);
        chk("blank_b1_an1", 32'(n), 32'(16 - ON_B1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
